// File: rtl/uart_pkg.sv
// Shared UART definitions for send_byte and receive_byte.
// Receiver option: RECEIVE_BYTE_PARITY_EN (8E1 frames).
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/receive_byte.sv
// UART receiver: oversampled 8N1 serial line to parallel byte with strobe.
// Define RECEIVE_BYTE_PARITY_EN for 8E1 frames and a parity_err pulse.
module receive_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
`ifdef RECEIVE_BYTE_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
    logic                 drop;
    logic                 half_hit;
    logic                 bit_hit;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx),
        .q_o  (rx_s)
    );

`ifdef RECEIVE_BYTE_PARITY_EN
    logic perr_q, perr_d;
    logic bad_q, bad_d;
    assign drop       = bad_q;
    assign parity_err = perr_q;
`else
    assign drop = 1'b0;
`endif

    assign half_hit    = (cnt_q == CW'(HALF - 1));
    assign bit_hit     = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RECEIVE_BYTE_PARITY_EN
        perr_d  = 1'b0;
        bad_d   = bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (half_hit) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef RECEIVE_BYTE_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef RECEIVE_BYTE_PARITY_EN
            PARITY: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    bad_d   = ^{shift_q, rx_s};
                    perr_d  = ^{shift_q, rx_s};
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_hit) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // back to IDLE at mid-stop so a frame may follow at once
                        if (!drop) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RECEIVE_BYTE_PARITY_EN
            perr_q  <= 1'b0;
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RECEIVE_BYTE_PARITY_EN
            perr_q  <= perr_d;
            bad_q   <= bad_d;
`endif
        end
    end

endmodule

// File: tb/tb_receive_byte.sv
// Bench for receive_byte with CLKS_PER_BIT=16; ideal frames driven on rx.
// Received bytes are checked against a queue of expected bytes.
module tb_receive_byte;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;
`ifdef RECEIVE_BYTE_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         pcnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int fcnt   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    always #5 clk = ~clk;

    receive_byte #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .framing_err(framing_err),
`ifdef RECEIVE_BYTE_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid data=%h required no strobe", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL rx_byte data=%h required %h", data, e);
                end
            end
        end
        if (framing_err) fcnt++;
`ifdef RECEIVE_BYTE_PARITY_EN
        if (parity_err) pcnt++;
`endif
        if (valid && framing_err) begin
            errors++;
            $display("FAIL strobe_overlap valid=1 framing_err=1 required exclusive");
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic push);
        if (push) exp_q.push_back(b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef RECEIVE_BYTE_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({data, valid, framing_err, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b/%b/%b required 0", data, valid, framing_err, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b valid=%b required 0 0", busy, valid);
        end
    endtask

    task automatic test_single;
        int f0;
        f0 = fcnt;
        idle(20);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(30);
        drain("single_drain");
        checks++;
        if (data !== 8'hA5) begin
            errors++;
            $display("FAIL single_data data=%h required a5", data);
        end
        checks++;
        if (fcnt != f0) begin
            errors++;
            $display("FAIL single_ferr count=%0d required %0d", fcnt, f0);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vcnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(30);
        drain("b2b_drain");
        checks++;
        if (vcnt - v0 != 3) begin
            errors++;
            $display("FAIL b2b_count strobes=%0d required 3", vcnt - v0);
        end
    endtask

    task automatic test_glitch;
        int v0, f0, n;
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < CPB) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy busy=%b required 0 within %0d clk", busy, CPB);
        end
        idle(20);
        checks++;
        if (vcnt != v0 || fcnt != f0) begin
            errors++;
            $display("FAIL glitch_strobe valid=%0d ferr=%0d required 0 0", vcnt - v0, fcnt - f0);
        end
        send_frame(8'h55, 1'b1, 1'b1);
        idle(20);
        drain("glitch_next");
    endtask

    task automatic test_framing;
        int v0, f0;
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            if (i == 7) rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
`ifdef RECEIVE_BYTE_PARITY_EN
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
`endif
        rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (fcnt - f0 != 1 || vcnt != v0) begin
            errors++;
            $display("FAIL framing_pulse ferr=%0d valid=%0d required 1 0", fcnt - f0, vcnt - v0);
        end
        checks++;
        if (data !== 8'h55) begin
            errors++;
            $display("FAIL framing_hold data=%h required 55", data);
        end
        idle(20);
        send_frame(8'h12, 1'b1, 1'b1);
        idle(20);
        drain("framing_next");
    endtask

    task automatic test_reset_mid;
        int v0;
        logic [7:0] b;
        b = 8'h77;
        v0 = vcnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data, valid, framing_err, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async got %h/%b/%b/%b required 0", data, valid, framing_err, busy);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        checks++;
        if (vcnt != v0) begin
            errors++;
            $display("FAIL reset_abort strobes=%0d required 0", vcnt - v0);
        end
        send_frame(8'h99, 1'b1, 1'b1);
        idle(20);
        drain("reset_next");
        checks++;
        if (data !== 8'h99) begin
            errors++;
            $display("FAIL reset_next_data data=%h required 99", data);
        end
    endtask

`ifdef RECEIVE_BYTE_PARITY_EN
    task automatic test_parity;
        int v0, p0;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        drain("parity_good");
        v0 = vcnt;
        p0 = pcnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        par_flip = 1'b0;
        checks++;
        if (pcnt - p0 != 1 || vcnt != v0) begin
            errors++;
            $display("FAIL parity_drop perr=%0d valid=%0d required 1 0", pcnt - p0, vcnt - v0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef RECEIVE_BYTE_PARITY_EN
        test_parity();
`endif
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
